// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order and the hex glyph set
// used by both the encoders and the scan decoder.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, bit6=g .. bit0=a
  localparam seg_t SEG_HEX_0     = 7'b0111111;
  localparam seg_t SEG_HEX_1     = 7'b0000110;
  localparam seg_t SEG_HEX_2     = 7'b1011011;
  localparam seg_t SEG_HEX_3     = 7'b1001111;
  localparam seg_t SEG_HEX_4     = 7'b1100110;
  localparam seg_t SEG_HEX_5     = 7'b1101101;
  localparam seg_t SEG_HEX_6     = 7'b1111101;
  localparam seg_t SEG_HEX_7     = 7'b0000111;
  localparam seg_t SEG_HEX_8     = 7'b1111111;
  localparam seg_t SEG_HEX_9     = 7'b1101111;
  localparam seg_t SEG_HEX_9_ALT = 7'b1100111;
  localparam seg_t SEG_HEX_A     = 7'b1110111;
  localparam seg_t SEG_HEX_B     = 7'b1111100;
  localparam seg_t SEG_HEX_C     = 7'b0111001;
  localparam seg_t SEG_HEX_D     = 7'b1011110;
  localparam seg_t SEG_HEX_E     = 7'b1111001;
  localparam seg_t SEG_HEX_F     = 7'b1110001;
  localparam seg_t SEG_BLANK     = 7'b0000000;

  function automatic seg_t seg_from_n(input seg_t seg_n);
    return ~seg_n;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph-to-nibble decoder; unrecognised patterns (blank
// included) report ok=0 with nibble 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t       i_seg,
  output logic       o_ok,
  output logic [3:0] o_nibble
);

  // Glyph lookup
  always_comb begin
    o_ok     = 1'b1;
    o_nibble = 4'h0;
    case (i_seg)
      SEG_HEX_0:                o_nibble = 4'h0;
      SEG_HEX_1:                o_nibble = 4'h1;
      SEG_HEX_2:                o_nibble = 4'h2;
      SEG_HEX_3:                o_nibble = 4'h3;
      SEG_HEX_4:                o_nibble = 4'h4;
      SEG_HEX_5:                o_nibble = 4'h5;
      SEG_HEX_6:                o_nibble = 4'h6;
      SEG_HEX_7:                o_nibble = 4'h7;
      SEG_HEX_8:                o_nibble = 4'h8;
      SEG_HEX_9, SEG_HEX_9_ALT: o_nibble = 4'h9;
      SEG_HEX_A:                o_nibble = 4'hA;
      SEG_HEX_B:                o_nibble = 4'hB;
      SEG_HEX_C:                o_nibble = 4'hC;
      SEG_HEX_D:                o_nibble = 4'hD;
      SEG_HEX_E:                o_nibble = 4'hE;
      SEG_HEX_F:                o_nibble = 4'hF;
      default: begin
        o_ok     = 1'b0;
        o_nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a scanned active-low 7-segment bus and rebuilds the displayed hex
// value. Optional frame watchdog enabled by defining SEG7_DEC_TIMEOUT_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_sel
`ifdef SEG7_DEC_TIMEOUT_EN
  ,
  output logic                    timeout
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NS_W  = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN   = '1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg7_scan_decoder: NUM_DIGITS must be 1..16");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("seg7_scan_decoder: STABLE_CYCLES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("seg7_scan_decoder: TIMEOUT_CYCLES must be >= 2");
  end

  // Input copies are kept active-high so the all-zero reset state reads as idle
  seg_t                    r_seg;
  seg_t                    r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [NUM_DIGITS-1:0]   r_prev_sel;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_frame_done;
  logic                    r_err_sel;

  logic [NS_W-1:0]       w_nsel;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_one;
  logic                  w_multi;
  logic                  w_same;
  logic                  w_commit;
  logic                  w_frame;
  logic                  w_tmo;
  logic [NUM_DIGITS-1:0] w_seen_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_ok;
  logic [3:0]            w_nib;

  seg7_pattern_decode u_decode (
    .i_seg    (r_seg),
    .o_ok     (w_ok),
    .o_nibble (w_nib)
  );

  // Select classification and stability/commit decision
  always_comb begin
    w_nsel = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nsel = w_nsel + NS_W'(r_sel[i]);
      w_idx  = r_sel[i] ? IDX_W'(i) : w_idx;
    end
    w_one       = (w_nsel == NS_W'(1));
    w_multi     = (w_nsel > NS_W'(1));
    w_same      = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);
    w_commit    = w_one && w_same && (r_cnt == CNT_COMMIT);
    w_seen_next = r_seen | r_sel;
    w_frame     = w_commit && (w_seen_next == ALL_SEEN);
    if (!w_one) begin
      w_cnt_next = '0;
    end else if (!w_same) begin
      w_cnt_next = CNT_ONE;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Input stage, previous-sample history and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= SEG_BLANK;
      r_sel      <= '0;
      r_prev_seg <= SEG_BLANK;
      r_prev_sel <= '0;
      r_cnt      <= '0;
    end else begin
      r_seg      <= seg_from_n(seg_n);
      r_sel      <= ~dig_sel_n;
      r_prev_seg <= r_seg;
      r_prev_sel <= r_sel;
      r_cnt      <= w_cnt_next;
    end
  end

  // Commit, frame tracking and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value      <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_frame_done <= 1'b0;
      r_err_sel    <= 1'b0;
    end else begin
      r_frame_done <= w_frame;
      // Pulse only on entry into a multi-select sample, not while it is held
      r_err_sel    <= w_multi && (r_sel != r_prev_sel);
      if (w_commit) begin
        r_value[{w_idx, 2'b00} +: 4] <= w_nib;
        r_valid[w_idx]               <= w_ok;
      end
      if (w_tmo) begin
        r_valid <= '0;
      end
      if (w_frame || w_tmo) begin
        r_seen <= '0;
      end else if (w_commit) begin
        r_seen <= w_seen_next;
      end
    end
  end

`ifdef SEG7_DEC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;

  // A completing frame in the expiry cycle suppresses the timeout
  always_comb begin
    w_tmo = (r_wdog == WD_LAST) && !w_frame;
  end

  // Frame watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= (w_frame || w_tmo) ? '0 : r_wdog + WD_W'(1);
      r_timeout <= w_tmo;
    end
  end

  assign timeout = r_timeout;
`else
  always_comb begin
    w_tmo = 1'b0;
  end
`endif

  assign value       = r_value;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err_sel     = r_err_sel;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: dwell-level reference model feeds
// an expected-event queue that a negedge monitor drains.
module tb_seg7_scan_decoder;

  localparam int ND = 8;
  localparam int S  = 4;
  localparam int TO = 64;
`ifdef SEG7_DEC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  drv_seg_n = 7'h7F;
  logic [7:0]  drv_sel_n = 8'hFF;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err_sel;
  logic        timeout;
`ifndef SEG7_DEC_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (drv_seg_n),
    .dig_sel_n   (drv_sel_n),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_sel     (err_sel)
`ifdef SEG7_DEC_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] value;
    logic [7:0]  valid;
    logic        fd;
    logic        err;
    logic        tmo;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;
  int  cyc     = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [31:0] m_value, p_value;
  logic [7:0]  m_valid, p_valid, m_seen, m_prev_sel_n;
  logic [6:0]  m_prev_seg_n;
  int          m_base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Active-low pattern -> {recognised, nibble}
  function automatic logic [4:0] ref_decode(input logic [6:0] p_n);
    logic [6:0] p;
    p = ~p_n;
    for (int i = 0; i < 16; i++) begin
      if (p == hex_tab[i]) return {1'b1, 4'(i)};
    end
    if (p == 7'h67) return {1'b1, 4'h9};
    return 5'h00;
  endfunction

  task automatic push_state(input int c, input logic fd, input logic err, input logic tmo);
    ev_t e;
    if (fd || err || tmo || m_value !== p_value || m_valid !== p_valid) begin
      e.cyc = c; e.value = m_value; e.valid = m_valid; e.fd = fd; e.err = err; e.tmo = tmo;
      exp_q.push_back(e);
      p_value = m_value;
      p_valid = m_valid;
    end
  endtask

  // Emit every watchdog expiry strictly before cycle c
  task automatic advance_to(input int c);
    while (TMO_EN && (m_base + TO < c)) begin
      m_base  = m_base + TO;
      m_valid = '0;
      m_seen  = '0;
      push_state(m_base, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic finish_at(input int c, input logic fd, input logic err);
    logic tmo;
    tmo = 1'b0;
    if (TMO_EN && fd) begin
      m_base = c;
    end else if (TMO_EN && (m_base + TO == c)) begin
      tmo = 1'b1; m_valid = '0; m_seen = '0; m_base = c;
    end
    push_state(c, fd, err, tmo);
  endtask

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_seen = '0; p_value = '0; p_valid = '0;
    m_prev_sel_n = 8'hFF; m_prev_seg_n = 7'h7F; m_base = cyc;
    exp_q.delete();
  endtask

  // Drive one dwell (called just after a rising edge) and predict its effects
  task automatic dwell(input logic [7:0] sel_n, input logic [6:0] p_n, input int len);
    int k, idx;
    logic [4:0] d;
    logic fd;
    k = cyc;
    drv_sel_n = sel_n;
    drv_seg_n = p_n;
    if ($countones(~sel_n) > 1 && sel_n != m_prev_sel_n) begin
      advance_to(k + 2);
      finish_at(k + 2, 1'b0, 1'b1);
    end
    if ($countones(~sel_n) == 1 && (sel_n != m_prev_sel_n || p_n != m_prev_seg_n) && len >= S) begin
      advance_to(k + S + 1);
      idx = 0;
      for (int i = 0; i < ND; i++) if (!sel_n[i]) idx = i;
      d = ref_decode(p_n);
      m_value[4*idx +: 4] = d[3:0];
      m_valid[idx] = d[4];
      m_seen[idx]  = 1'b1;
      fd = (m_seen == 8'hFF);
      if (fd) m_seen = '0;
      finish_at(k + S + 1, fd, 1'b0);
    end
    advance_to(k + len + 2);
    m_prev_sel_n = sel_n;
    m_prev_seg_n = p_n;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_sel_n = 8'hFF;
    drv_seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any visible output activity must match the queue head
  always @(negedge clk) begin
    ev_t e;
    logic [31:0] last_value;
    logic [7:0]  last_valid;
    if (!rst_n) begin
      last_value = '0;
      last_valid = '0;
    end else if (frame_done || err_sel || timeout || value !== last_value || digit_valid !== last_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_value", value, e.value);
        chk("ev_digit_valid", digit_valid, e.valid);
        chk("ev_frame_done", frame_done, e.fd);
        chk("ev_err_sel", err_sel, e.err);
        chk("ev_timeout", timeout, e.tmo);
      end
      last_value = value;
      last_valid = digit_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sel;
    logic [6:0] pat;
    int r, a, b;
    #2;
    do_reset();
    chk("reset_value", value, 32'h0);
    chk("reset_digit_valid", digit_valid, 8'h0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_err_sel", err_sel, 1'b0);
    chk("reset_timeout", timeout, 1'b0);

    dwell(8'hF7, ~7'b1011011, 10);
    dwell(8'hFB, ~7'b1011011, 3);
    dwell(8'hFB, ~7'b1001111, 4);
    dwell(8'hFF, 7'h7F, 3);
    chk("glitch_digit2", value[11:8], 4'h3);

    do_reset();
    for (int d = 7; d >= 0; d--) begin
      a = (d == 7) ? 1 : (d == 6) ? 2 : (d == 5) ? 3 : (d == 4) ? 4 : 10 + (3 - d);
      dwell(~(8'h01 << d), ~hex_tab[a], 6);
    end
    chk("frame_value", value, 32'h1234ABCD);
    chk("frame_digit_valid", digit_valid, 8'hFF);
`ifdef SEG7_DEC_TIMEOUT_EN
    dwell(8'hFF, 7'h7F, 70);
    chk("timeout_value_held", value, 32'h1234ABCD);
    chk("timeout_digit_valid", digit_valid, 8'h00);
`endif

    dwell(8'hFC, ~hex_tab[8], 3);
    dwell(8'hFE, ~7'b0000001, 6);
    chk("bad_pattern_value", value[3:0], 4'h0);
    chk("bad_pattern_valid", digit_valid[0], 1'b0);
    dwell(8'hFE, ~7'b1100111, 6);
    dwell(8'hFF, 7'h7F, 2);
    chk("alt9_value", value[3:0], 4'h9);

    for (int n = 0; n < 200; n++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          sel = ~(8'h01 << $urandom_range(0, 7));
        end else if (r == 7) begin
          sel = 8'hFF;
        end else begin
          a = $urandom_range(0, 7);
          b = (a + 1 + $urandom_range(0, 6)) % 8;
          sel = ~((8'h01 << a) | (8'h01 << b));
        end
        pat = ($urandom_range(0, 3) != 0) ? ~hex_tab[$urandom_range(0, 15)] : 7'($urandom);
      end while (sel == m_prev_sel_n && pat == m_prev_seg_n);
      dwell(sel, pat, $urandom_range(1, 8));
    end

    dwell(8'hFE, ~hex_tab[1], 6);
    dwell(8'hFF, 7'h7F, 3);
    chk("queue_drained_before_reset", exp_q.size(), 0);
    drv_sel_n = 8'hDF;
    drv_seg_n = ~hex_tab[10];
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_value", value, 32'h0);
    chk("async_reset_digit_valid", digit_valid, 8'h0);
    chk("async_reset_frame_done", frame_done, 1'b0);
    chk("async_reset_err_sel", err_sel, 1'b0);
    drv_sel_n = 8'hFF;
    drv_seg_n = 7'h7F;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) dwell(~(8'h01 << d), ~hex_tab[15 - d], 5);

    dwell(8'hFF, 7'h7F, 10);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Recovers hex digits from a time-multiplexed, active-low 7-segment display bus. This is the inverse of the team's hex-to-segment encoders. The block snoops the segment lines and per-digit selects driven by a scanning display driver. It debounces each digit dwell and decodes the segment pattern back to a nibble. It assembles a NUM_DIGITS-wide hex value with per-digit validity and a frame-complete strobe. It is used as a bench checker and as a loopback monitor beside the HEX display path.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..16)
STABLE_CYCLES, 4, identical consecutive samples required before a commit (>=2)
TIMEOUT_CYCLES, 65536, frame watchdog period; used only with SEG7_DEC_TIMEOUT_EN

Ports:
clk  input  1  system clock
rst_n  input  1  reset
seg_n  input  7  segment lines, active-low, bit0=a .. bit6=g
dig_sel_n  input  NUM_DIGITS  digit selects, active-low, one-hot when valid
value  output  4*NUM_DIGITS  decoded digits; digit i at value[4i+3:4i]
digit_valid  output  NUM_DIGITS  1 = last committed pattern of digit i was recognised
frame_done  output  1  one-cycle pulse: every digit committed since last pulse
err_sel  output  1  one-cycle pulse: more than one select active
timeout  output  1  one-cycle pulse; present only with SEG7_DEC_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: value=0, digit_valid=0, frame_done=0, err_sel=0, timeout=0. Internal input registers, stability counter, seen mask and watchdog are all 0.
- Input stage: seg_n and dig_sel_n are registered once. All logic below operates on the registered copies.
- Select classification:
  - No select active: idle. Counter is cleared.
  - More than one select active: err_sel pulses in the following cycle. Counter is cleared and nothing is committed.
  - Exactly one select active: index idx is valid.
- Stability counter cnt, saturating at STABLE_CYCLES:
  - With a valid idx, if (idx, seg) equals the previous registered sample, cnt increments. Otherwise cnt is set to 1.
  - Commit happens on the cycle cnt steps from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Exactly one commit per dwell. A held pattern never recommits.
- Latency: with select and pattern held constant from port cycle 0, value and digit_valid update on rising edge STABLE_CYCLES+1.
- Commit action:
  - value[4idx+:4] takes the decoded nibble.
  - digit_valid[idx] takes the recognised flag.
  - seen[idx] is set.
  - Other digits are unchanged.
- Decode table, active-high g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111 or 1100111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - Any other pattern, including blank, gives nibble 0 and recognised 0.
- Frame:
  - When a commit makes seen all-ones, frame_done pulses on the same edge that writes that commit's value.
  - seen clears to 0 on that same edge.
  - A digit recommitted before the frame completes simply overwrites its value. It does not double-count.
- A select or pattern change mid-dwell restarts the counter. No partial commit occurs.
- Reset mid-dwell or mid-frame clears everything. The next frame requires all digits again.

Optional Feature:
- SEG7_DEC_TIMEOUT_EN defined:
  - A watchdog counts cycles since the last frame_done or reset.
  - On reaching TIMEOUT_CYCLES-1, timeout pulses one cycle and digit_valid clears to 0. value is held.
  - seen clears and the watchdog restarts.
  - A frame_done in the same cycle wins: no timeout, watchdog restarts.
- Undefined: no watchdog logic and no timeout port. digit_valid changes only on commit.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t (7-bit segment vector);
  - localparams SEG_A..SEG_G bit indices;
  - constants SEG_HEX_0..SEG_HEX_F, shared with the encoders;
  - the alternate 9 pattern SEG_HEX_9_ALT.
- One sub-module, seg7_pattern_decode: combinational seg_t to {ok, nibble[3:0]}.
- Counter, seen mask and watchdog stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-dwell, asynchronously and between edges. All outputs go to 0 immediately. A following full scan is required before frame_done.
- Single commit:
  - Stimulus: dig_sel_n=8'hF7, seg_n=~7'b1011011, held 10 cycles.
  - Response: on edge 5, value[15:12]=4'h2 and digit_valid[3]=1.
  - No further output activity.
- Glitch rejection: hold a pattern 3 cycles, then change seg_n to ~7'b1001111 and hold 4 cycles. Only 4'h3 is committed; 4'h2 never appears.
- Full frame:
  - Stimulus: scan digits 7..0 with 1,2,3,4,A,b,C,d, each for 6 cycles.
  - Response: value=32'h1234ABCD, all digit_valid=1.
  - frame_done pulses exactly once, on the digit-0 commit edge.
- Errors:
  - dig_sel_n=8'hFC gives one err_sel pulse and no commit.
  - Digit 0 with pattern 7'b0000001 gives value[3:0]=0 and digit_valid[0]=0.
  - Pattern 1100111 decodes to 9.
- Timeout (macro defined, TIMEOUT_CYCLES=64): after one frame, idle 64 cycles. timeout pulses once, digit_valid=0, and value stays 32'h1234ABCD.
